// File: rtl/log2_pipe.sv
// rtl/log2_pipe.sv - pipelined fixed-point log2 with valid/ready handshake and tag sideband
//
// Purpose:
//   Computes y = log2(x) for an unsigned DATA_W-bit operand as an unsigned
//   INT_W.FRAC_W fixed-point value. The integer part comes from a leading-one
//   detector in stage 0. Each following stage squares the normalised mantissa
//   and emits one fractional bit, MSB first. A tag travels with every operand.
//
// Optional feature (macro LOG2_ROUND_EN):
//   When defined, one extra squaring stage produces fraction bit FRAC_W+1.
//   The result is rounded half-up and saturates at all ones. Latency becomes
//   FRAC_W+2. When undefined, results are truncated and latency is FRAC_W+1.
//
// Ports:
//   clk     in   1       rising-edge clock
//   rst_n   in   1       asynchronous active-low reset
//   x       in   DATA_W  unsigned operand
//   tagx    in   TAG_W   tag accompanying x
//   validx  in   1       x/tagx valid
//   readyx  out  1       block can accept (transfer on validx && readyx)
//   y       out  Y_W     result, INT_W.FRAC_W unsigned
//   tagy    out  TAG_W   tag aligned with y
//   zeroy   out  1       x was 0, y forced to 0
//   validy  out  1       y/tagy/zeroy valid
//   readyy  in   1       downstream accepts (transfer on validy && readyy)

module log2_pipe #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int TAG_W  = 4,
  localparam int INT_W = $clog2(DATA_W),
  localparam int Y_W   = INT_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] x,
  input  logic [TAG_W-1:0]  tagx,
  input  logic              validx,
  output logic              readyx,
  output logic [Y_W-1:0]    y,
  output logic [TAG_W-1:0]  tagy,
  output logic              zeroy,
  output logic              validy,
  input  logic              readyy
);

`ifdef LOG2_ROUND_EN
  localparam int NSQ = FRAC_W + 1;
`else
  localparam int NSQ = FRAC_W;
`endif

  // Stage 0 normalises; stages 1..NSQ each square once. The mantissa is not
  // needed after the last squaring, so it is only kept for stages 0..NSQ-1.
  logic [NSQ:0]                 v_q,    v_d;
  logic [NSQ:0][TAG_W-1:0]      tag_q,  tag_d;
  logic [NSQ:0]                 zero_q, zero_d;
  logic [NSQ:0][INT_W-1:0]      int_q,  int_d;
  logic [NSQ:0][NSQ-1:0]        frac_q, frac_d;
  logic [NSQ-1:0][DATA_W-1:0]   m_q,    m_d;

  logic                         en;
  logic [INT_W-1:0]             lod_p;
  logic                         lod_found;
  logic [DATA_W-1:0]            m0;

  // The whole pipe moves as one: it only stalls when a finished result is
  // waiting at the output and downstream is not taking it.
  assign en     = ~v_q[NSQ] | readyy;
  assign readyx = en;

  // Leading-one detector: the last hit while scanning upward is the MSB.
  always_comb begin
    lod_p     = '0;
    lod_found = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (x[i]) begin
        lod_p     = INT_W'(i);
        lod_found = 1'b1;
      end
    end
  end

  // Shift the leading one up to the MSB so m is 1.(DATA_W-1) in [1,2).
  assign m0 = lod_found ? (x << (INT_W'(DATA_W - 1) - lod_p)) : '0;

  always_comb begin
    logic [2*DATA_W-1:0] sq;
    logic                fbit;

    v_d       = '0;
    tag_d     = '0;
    zero_d    = '0;
    int_d     = '0;
    frac_d    = '0;
    m_d       = '0;
    sq        = '0;
    fbit      = 1'b0;

    v_d[0]    = validx;
    tag_d[0]  = tagx;
    zero_d[0] = ~lod_found;
    int_d[0]  = lod_p;
    m_d[0]    = m0;

    for (int k = 1; k <= NSQ; k++) begin
      // m in [1,2) so m*m is in [1,4); the top bit says whether it reached 2.
      sq        = {{DATA_W{1'b0}}, m_q[k-1]} * {{DATA_W{1'b0}}, m_q[k-1]};
      fbit      = sq[2*DATA_W-1];
      v_d[k]    = v_q[k-1];
      tag_d[k]  = tag_q[k-1];
      zero_d[k] = zero_q[k-1];
      int_d[k]  = int_q[k-1];
      frac_d[k] = (frac_q[k-1] << 1) | NSQ'(fbit);
      if (k < NSQ) begin
        // Renormalise to [1,2) by dropping either one or zero extra LSBs.
        m_d[k] = fbit ? DATA_W'(sq >> DATA_W) : DATA_W'(sq >> (DATA_W - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      tag_q  <= '0;
      zero_q <= '0;
      int_q  <= '0;
      frac_q <= '0;
      m_q    <= '0;
    end else if (en) begin
      v_q    <= v_d;
      tag_q  <= tag_d;
      zero_q <= zero_d;
      int_q  <= int_d;
      frac_q <= frac_d;
      m_q    <= m_d;
    end
  end

  assign validy = v_q[NSQ];
  assign tagy   = tag_q[NSQ];
  assign zeroy  = zero_q[NSQ];

  // A zero operand carries int=0 and m=0 down the pipe, so every fraction
  // bit is 0 and y is 0 without a separate mux.
`ifdef LOG2_ROUND_EN
  logic [Y_W:0] y_sum;

  assign y_sum = {1'b0, int_q[NSQ], frac_q[NSQ][NSQ-1:1]} + (Y_W + 1)'(frac_q[NSQ][0]);
  assign y     = y_sum[Y_W] ? '1 : y_sum[Y_W-1:0];
`else
  assign y     = {int_q[NSQ], frac_q[NSQ]};
`endif

endmodule

// File: tb/tb_log2_pipe.sv
// tb/tb_log2_pipe.sv - self-checking bench for log2_pipe

module tb_log2_pipe;

  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;
  localparam int TAG_W  = 4;
  localparam int INT_W  = $clog2(DATA_W);
  localparam int Y_W    = INT_W + FRAC_W;
`ifdef LOG2_ROUND_EN
  localparam int NSQ = FRAC_W + 1;
`else
  localparam int NSQ = FRAC_W;
`endif
  localparam int LAT = NSQ + 1;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] x;
  logic [TAG_W-1:0]  tagx;
  logic              validx;
  logic              readyx;
  logic [Y_W-1:0]    y;
  logic [TAG_W-1:0]  tagy;
  logic              zeroy;
  logic              validy;
  logic              readyy;

  log2_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (x),
    .tagx   (tagx),
    .validx (validx),
    .readyx (readyx),
    .y      (y),
    .tagy   (tagy),
    .zeroy  (zeroy),
    .validy (validy),
    .readyy (readyy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [Y_W-1:0]   y;
    logic [TAG_W-1:0] tag;
    logic             zero;
    int               acc;
    bit               chk;
  } exp_t;

  typedef struct {
    logic [DATA_W-1:0] x;
    logic [TAG_W-1:0]  tag;
    logic [Y_W-1:0]    y;
    logic              zero;
  } vec_t;

  exp_t sb[$];
  vec_t tab[7];

  int total   = 0;
  int bad     = 0;
  int cyc     = 0;
  int out_cnt = 0;
  int base;
  int run;
  int nwait;
  logic [DATA_W-1:0] rv;
  logic [DATA_W-1:0] rv2;
  logic [Y_W-1:0]    y_hold;
  logic [TAG_W-1:0]  t_hold;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [Y_W-1:0] model(input logic [DATA_W-1:0] xv);
    logic [DATA_W-1:0]   m;
    logic [2*DATA_W-1:0] sq;
    logic [NSQ-1:0]      fr;
    logic [INT_W-1:0]    p;
    logic [Y_W:0]        s;
    if (xv == 0) return '0;
    p = '0;
    for (int i = 0; i < DATA_W; i++) if (xv[i]) p = INT_W'(i);
    m  = xv << (DATA_W - 1 - int'(p));
    fr = '0;
    for (int k = 0; k < NSQ; k++) begin
      sq = (2*DATA_W)'(m) * (2*DATA_W)'(m);
      fr = (fr << 1) | NSQ'(sq[2*DATA_W-1]);
      m  = sq[2*DATA_W-1] ? sq[2*DATA_W-1 -: DATA_W] : sq[2*DATA_W-2 -: DATA_W];
    end
`ifdef LOG2_ROUND_EN
    s = {1'b0, p, fr[NSQ-1:1]} + (Y_W + 1)'(fr[0]);
    return s[Y_W] ? '1 : s[Y_W-1:0];
`else
    s = '0;
    return {p, fr};
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Output scoreboard: every handshake at the output pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && validy && readyy) begin
      total++;
      out_cnt++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL stale_output: got y=%h tag=%h zero=%b want no output", y, tagy, zeroy);
      end else begin
        e = sb.pop_front();
        if ({y, tagy, zeroy} !== {e.y, e.tag, e.zero}) begin
          bad++;
          $display("FAIL result_tag%0h: got y=%h tag=%h zero=%b want y=%h tag=%h zero=%b",
                   e.tag, y, tagy, zeroy, e.y, e.tag, e.zero);
        end
        if (e.chk) begin
          total++;
          if (cyc - e.acc + 1 != LAT) begin
            bad++;
            $display("FAIL latency_tag%0h: got %0d want %0d", e.tag, cyc - e.acc + 1, LAT);
          end
        end
      end
    end
  end

  // Drives one operand; leaves validx high so back-to-back calls stream.
  task automatic send(input logic [DATA_W-1:0] xv, input logic [TAG_W-1:0] tv,
                      input logic [Y_W-1:0] ye, input logic ze, input bit lat_chk);
    exp_t e;
    int   n;
    bit   ok;
    x = xv; tagx = tv; validx = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 60) begin
      @(negedge clk);
      if (readyx) ok = 1'b1;
      n++;
    end
    if (ok) begin
      e.y = ye; e.tag = tv; e.zero = ze; e.acc = cyc + 1; e.chk = lat_chk;
      sb.push_back(e);
    end else begin
      total++; bad++;
      $display("FAIL send_timeout: got readyx=0 want 1 for tag %0h", tv);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk(nm, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected values hold for both truncating and rounded builds.
    tab[0] = '{x: 8'd1,   tag: 4'h1, y: 7'h00, zero: 1'b0};
    tab[1] = '{x: 8'd128, tag: 4'h2, y: 7'h70, zero: 1'b0};
    tab[2] = '{x: 8'd3,   tag: 4'h3, y: 7'h19, zero: 1'b0};
    tab[3] = '{x: 8'd255, tag: 4'h4, y: 7'h7F, zero: 1'b0};
    tab[4] = '{x: 8'd0,   tag: 4'hA, y: 7'h00, zero: 1'b1};
    tab[5] = '{x: 8'd2,   tag: 4'h5, y: 7'h10, zero: 1'b0};
    tab[6] = '{x: 8'd64,  tag: 4'h6, y: 7'h60, zero: 1'b0};

    rst_n = 1'b0; validx = 1'b0; x = '0; tagx = '0; readyy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_validy", 32'(validy), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_tagy", 32'(tagy), 0);
    chk("rst_zeroy", 32'(zeroy), 0);
    chk("rst_readyx", 32'(readyx), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single transfers with latency check.
    for (int i = 0; i < 7; i++) begin
      send(tab[i].x, tab[i].tag, tab[i].y, tab[i].zero, 1'b1);
      validx = 1'b0;
      drain("single_drain");
    end

    // Back-pressure: six items, output held for seven cycles.
    base = out_cnt;
    readyy = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          rv = 8'($urandom_range(0, 255));
          send(rv, TAG_W'(i), model(rv), rv == 0, 1'b0);
        end
        validx = 1'b0;
      end
      begin
        nwait = 0;
        while (!validy && nwait < 40) begin
          @(negedge clk);
          nwait++;
        end
        chk("bp_validy_seen", 32'(validy), 1);
        y_hold = y;
        t_hold = tagy;
        for (int c = 0; c < 7; c++) begin
          chk("bp_readyx_low", 32'(readyx), 0);
          chk("bp_y_stable", 32'(y), 32'(y_hold));
          chk("bp_tagy_stable", 32'(tagy), 32'(t_hold));
          @(negedge clk);
        end
        @(posedge clk); #1;
        readyy = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", out_cnt - base, 6);

    // Throughput: 20 back-to-back operands.
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          rv2 = 8'($urandom_range(0, 255));
          send(rv2, TAG_W'(i), model(rv2), rv2 == 0, i == 0);
        end
        validx = 1'b0;
      end
      begin
        nwait = 0;
        while (!validy && nwait < 60) begin
          @(negedge clk);
          nwait++;
        end
        run = 0;
        for (int c = 0; c < 20; c++) begin
          if (validy) run++;
          @(negedge clk);
        end
        chk("thru_consecutive", run, 20);
      end
    join
    drain("thru_drain");
    chk("thru_count", out_cnt - base, 20);

    // Reset with three items in flight.
    readyy = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(10 + i), TAG_W'(12 + i), 7'h00, 1'b0, 1'b0);
    validx = 1'b0;
    nwait = 0;
    while (!validy && nwait < 20) begin
      @(posedge clk); #1;
      nwait++;
    end
    chk("mid_validy_before", 32'(validy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_validy_async", 32'(validy), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("mid_validy_held", 32'(validy), 0);
    rst_n = 1'b1;
    readyy = 1'b1;
    @(posedge clk); #1;
    send(8'd64, 4'h7, 7'h60, 1'b0, 1'b1);
    validx = 1'b0;
    drain("mid_drain");
    repeat (10) @(posedge clk);
    #1;
    chk("mid_idle_validy", 32'(validy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/log2_pipe.md
Name: log2_pipe

Overview:
- Pipelined fixed-point log2 unit with a parametrised unsigned input width and fractional output precision.
- Integer part comes from a leading-one detector. Fractional bits come from iterative mantissa squaring, one bit per pipeline stage.
- Uses a valid/ready handshake on both sides and carries a sideband tag through the pipe.
- Generalises the earlier fixed 8-bit, valid-only log2 block. It sits between a sample producer and downstream DSP logic.

Parameters:
- DATA_W, 8: input width in bits; must be ≥ 2.
- FRAC_W, 4: number of fractional output bits; must be ≥ 1.
- TAG_W, 4: sideband tag width, passed through aligned with data.
- Derived INT_W = $clog2(DATA_W).
- Derived Y_W = INT_W + FRAC_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x  in  DATA_W  unsigned operand.
- tagx  in  TAG_W  sideband tag accompanying x.
- validx  in  1  x/tagx valid.
- readyx  out  1  block can accept; transfer occurs when validx && readyx.
- y  out  Y_W  result, format INT_W.FRAC_W unsigned.
- tagy  out  TAG_W  tag aligned with y.
- zeroy  out  1  x was 0; y forced to 0.
- validy  out  1  y/tagy/zeroy valid.
- readyy  in  1  downstream accepts; transfer occurs when validy && readyy.

Behaviour:
- Reset (async assert, sync release): all stage valid bits clear.
  - validy = 0, y = 0, tagy = 0, zeroy = 0.
  - Data registers clear.
- Global enable: en = ~validy | readyy.
  - readyx = en, combinational.
  - When en = 0, every stage holds and no input is taken.
  - Bubbles advance when en = 1.
- Stage 0, on accept:
  - p = index of the most significant 1 in x.
  - int = p.
  - Mantissa m = x << (DATA_W-1-p), DATA_W bits, format 1.(DATA_W-1), so m is in [1,2).
  - If x == 0: int = 0, m = 0, zero flag = 1.
- Stages 1..FRAC_W: sq = m*m, 2*DATA_W bits.
  - If sq[2*DATA_W-1] = 1: fraction bit = 1, m_next = sq[2*DATA_W-1 -: DATA_W].
  - Otherwise: bit = 0, m_next = sq[2*DATA_W-2 -: DATA_W].
  - Truncation is exact and bit-defined; the bench model must match bit-exactly.
  - Bits are produced MSB first.
- Output: y = {int, frac}. For a zero input, y = 0 and zeroy = 1.
- Latency: FRAC_W+1 enabled cycles from accept to validy.
  - Full throughput is 1 result per cycle while readyy = 1.
- Back-pressure: while validy && ~readyy, y, tagy and zeroy stay stable.
  - No data is lost or duplicated.
- Simultaneous accept on input and output in the same cycle is legal.
- Reset mid-operation: all in-flight results are discarded and validy drops immediately.
- Ordering: strictly in order; tags are never reordered.

Optional Feature:
- LOG2_ROUND_EN defined:
  - One extra squaring stage computes fraction bit FRAC_W+1. Latency = FRAC_W+2.
  - Result is rounded half-up: y = {int,frac} + extra_bit.
  - If the sum exceeds 2^Y_W - 1, y saturates to all ones.
  - zeroy behaviour is unchanged.
- Not defined: results are truncated and latency = FRAC_W+1.

Test Plan (DATA_W=8, FRAC_W=4, TAG_W=4, truncating unless noted):
- Single transfers with readyy = 1:
  - x=1, tag=1 -> y=0x00, tagy=1, zeroy=0, 5 cycles after accept.
  - x=128 -> y=0x70.
  - x=3 -> y=0x19 (25 = 1.5625).
  - x=255 -> y=0x7F.
- Zero input: x=0, tag=0xA -> y=0, zeroy=1, tagy=0xA.
  - The next input x=2 gives y=0x10 with zeroy=0.
- Back-pressure: stream 6 random values with tags 0..5, hold readyy=0 for 7 cycles.
  - readyx falls once validy asserts.
  - y/tagy stay stable.
  - After release, exactly 6 results arrive in tag order, matching the model.
- Throughput: continuous validx with readyy=1 for 20 samples -> 20 consecutive validy cycles after a 5-cycle fill.
- Reset mid-stream: assert rst_n=0 with 3 items in flight.
  - validy=0 immediately.
  - After release, the first new input x=64 -> y=0x60, and no stale outputs appear.
- LOG2_ROUND_EN:
  - x=255 -> y=0x7F (saturated), latency 6.
  - x=3 -> y=0x19.
  - x=1 -> y=0x00.
